// File: rtl/controlador_frota_if.sv
// ---------------------------------------------------------------------------
// controlador_frota_if
//
// Bus between the fleet sequencer and the array of enemy / enemy-projectile
// instances.
//
//   vivo        : bit i = enemy i alive                    (enemies -> sequencer)
//   x_inimigos  : packed x of enemy i at [10i+9:10i]        (enemies -> sequencer)
//   bola_livre  : bit i = projectile of enemy i is idle     (enemies -> sequencer)
//   mv_tick     : one-cycle shared movement pulse           (sequencer -> enemies)
//   sentidoX    : shared horizontal direction, 1 = right    (sequencer -> enemies)
//   disparo     : one-hot, one-cycle fire grant             (sequencer -> enemies)
//
// The "master" side is the enemy array / game top level, the "slave" side is
// the sequencer itself.
// ---------------------------------------------------------------------------
interface controlador_frota_if #(
    parameter int N_INIMIGOS = 8
) ();

    logic [N_INIMIGOS-1:0]    vivo;
    logic [10*N_INIMIGOS-1:0] x_inimigos;
    logic [N_INIMIGOS-1:0]    bola_livre;
    logic                     mv_tick;
    logic                     sentidoX;
    logic [N_INIMIGOS-1:0]    disparo;

    modport master (
        output vivo,
        output x_inimigos,
        output bola_livre,
        input  mv_tick,
        input  sentidoX,
        input  disparo
    );

    modport slave (
        input  vivo,
        input  x_inimigos,
        input  bola_livre,
        output mv_tick,
        output sentidoX,
        output disparo
    );

endinterface

// File: rtl/controlador_frota.sv
// ---------------------------------------------------------------------------
// controlador_frota
//
// Central sequencer of the enemy formation. It produces the shared movement
// tick and horizontal direction, reverses the direction when the formation
// is about to leave the screen, and hands the single firing slot to one live
// enemy with an idle projectile in round-robin order.
//
// Ports:
//   CLOCK_50       : system clock, everything changes on its rising edge
//   reset          : asynchronous, active-low
//   pausa          : 1 freezes counters and grants
//   reiniciarJogo  : synchronous restart (same state as after reset)
//   frota          : enemy bus (vivo, x_inimigos, bola_livre in;
//                    mv_tick, sentidoX, disparo out)
//   frota_vazia    : 1 while the formation is wiped out (VITORIA)
// ---------------------------------------------------------------------------
module controlador_frota #(
    parameter int N_INIMIGOS = 8,
    parameter int DIV_MV     = 500000,
    parameter int DIV_TIRO   = 25000000,
    parameter int X_MIN      = 0,
    parameter int X_MAX      = 639,
    parameter int LARGURA    = 33,
    parameter int PASSO_X    = 2
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               pausa,
    input  logic               reiniciarJogo,
    controlador_frota_if.slave frota,
    output logic               frota_vazia
);

    localparam int MV_W   = (DIV_MV   > 1)     ? $clog2(DIV_MV)     : 1;
    localparam int TIRO_W = (DIV_TIRO > 1)     ? $clog2(DIV_TIRO)   : 1;
    localparam int PTR_W  = (N_INIMIGOS > 1)   ? $clog2(N_INIMIGOS) : 1;

    localparam logic [MV_W-1:0]   MV_FIM   = MV_W'(DIV_MV - 1);
    localparam logic [TIRO_W-1:0] TIRO_FIM = TIRO_W'(DIV_TIRO - 1);

    // Boundary constants in 12-bit arithmetic so that x + width + two steps
    // can never wrap for any 10-bit x.
    localparam logic [11:0] LIMITE_DIR = 12'(X_MAX + 1);
    localparam logic [11:0] ALCANCE    = 12'(LARGURA + 2 * PASSO_X);
    localparam logic [11:0] LIMITE_ESQ = 12'(X_MIN + 2 * PASSO_X);

    typedef enum logic [1:0] {
        JOGANDO = 2'd0,
        PAUSADO = 2'd1,
        VITORIA = 2'd2
    } estado_t;

    estado_t estado;
    estado_t prox_estado;

    logic                  ativo;

    logic [MV_W-1:0]       cnt_mv;
    logic [TIRO_W-1:0]     cnt_tiro;
    logic                  pendente;
    logic [PTR_W-1:0]      ptr;

    logic                  mv_tick_r;
    logic                  sentido_r;
    logic [N_INIMIGOS-1:0] disparo_r;

    logic                  algum_vivo;
    logic [11:0]           x_max;
    logic [11:0]           x_min;
    logic [11:0]           x_atual;
    logic                  vira_esq;
    logic                  vira_dir;

    logic [N_INIMIGOS-1:0] elegivel;
    logic                  achou;
    logic [PTR_W-1:0]      escolhido;
    logic [PTR_W-1:0]      candidato;
    int                    idx;
    logic [N_INIMIGOS-1:0] concessao;

    assign frota.mv_tick  = mv_tick_r;
    assign frota.sentidoX = sentido_r;
    assign frota.disparo  = disparo_r;
    assign frota_vazia    = (estado == VITORIA);

    // State register. Everything else in the block keys off this state,
    // so it is the only place the asynchronous reset puts the game back
    // into play.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            estado <= JOGANDO;
        end else begin
            estado <= prox_estado;
        end
    end

    // Next-state logic. Restart beats everything, a wiped-out fleet is
    // terminal until restart, and pause only applies while enemies remain.
    // "ativo" marks a cycle in which the game really advances: we are in
    // play and nothing this cycle is about to take us out of it. Using the
    // live inputs here makes pause and victory freeze the counters in the
    // very cycle they are raised instead of one cycle late.
    always_comb begin
        prox_estado = estado;
        ativo       = 1'b0;
        if (reiniciarJogo) begin
            prox_estado = JOGANDO;
        end else if (estado == VITORIA) begin
            prox_estado = VITORIA;
        end else if (frota.vivo == '0) begin
            prox_estado = VITORIA;
        end else if (pausa) begin
            prox_estado = PAUSADO;
        end else begin
            prox_estado = JOGANDO;
        end
        ativo = (estado == JOGANDO) && (prox_estado == JOGANDO) && !reiniciarJogo;
    end

    // Formation extents over live enemies only. Dead enemies keep whatever
    // x they had and must not drag the edge detection around.
    always_comb begin
        algum_vivo = 1'b0;
        x_max      = '0;
        x_min      = 12'hFFF;
        x_atual    = '0;
        for (int i = 0; i < N_INIMIGOS; i++) begin
            x_atual = {2'b00, frota.x_inimigos[10*i +: 10]};
            if (frota.vivo[i]) begin
                algum_vivo = 1'b1;
                if (x_atual > x_max) begin
                    x_max = x_atual;
                end
                if (x_atual < x_min) begin
                    x_min = x_atual;
                end
            end
        end
    end

    // The enemies take one more step in the old direction at the tick that
    // decides the flip, and the new direction only shows up at the following
    // tick, so the check looks two steps ahead.
    always_comb begin
        vira_esq = sentido_r  && algum_vivo && ((x_max + ALCANCE) > LIMITE_DIR);
        vira_dir = !sentido_r && algum_vivo && (x_min < LIMITE_ESQ);
    end

    // Round-robin search starting just after the last winner. The first
    // eligible index found wins; the running "achou" flag keeps later
    // candidates from overriding it.
    always_comb begin
        elegivel  = frota.vivo & frota.bola_livre;
        achou     = 1'b0;
        escolhido = '0;
        candidato = '0;
        idx       = 0;
        for (int k = 1; k <= N_INIMIGOS; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N_INIMIGOS) begin
                idx = idx - N_INIMIGOS;
            end
            candidato = PTR_W'(idx);
            if (!achou && elegivel[candidato]) begin
                achou     = 1'b1;
                escolhido = candidato;
            end
        end
        concessao = N_INIMIGOS'(1) << escolhido;
    end

    // Movement divider. The tick is registered and lasts exactly the cycle
    // after the wrap, so the enemies see it for one edge only. A paused
    // game simply stops counting; a won game starts from zero next time.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            cnt_mv    <= '0;
            mv_tick_r <= 1'b0;
        end else if (reiniciarJogo || estado == VITORIA) begin
            cnt_mv    <= '0;
            mv_tick_r <= 1'b0;
        end else begin
            mv_tick_r <= 1'b0;
            if (ativo) begin
                if (cnt_mv == MV_FIM) begin
                    cnt_mv    <= '0;
                    mv_tick_r <= 1'b1;
                end else begin
                    cnt_mv <= cnt_mv + 1'b1;
                end
            end
        end
    end

    // Direction register. It is evaluated at the edge where the enemies
    // consume the tick, using the formation extents they present right
    // then. The direction is left alone in pause and victory; only a
    // restart forces it back to the right.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            sentido_r <= 1'b1;
        end else if (reiniciarJogo) begin
            sentido_r <= 1'b1;
        end else if (mv_tick_r) begin
            if (vira_esq) begin
                sentido_r <= 1'b0;
            end else if (vira_dir) begin
                sentido_r <= 1'b1;
            end
        end
    end

    // Fire divider and arbiter. A terminal count raises a single pending
    // request; the request is served by the first eligible enemy on a later
    // cycle and keeps retrying while nobody can fire. When a grant and a
    // new terminal count land on the same edge the new request survives,
    // because it belongs to the next period.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            cnt_tiro  <= '0;
            pendente  <= 1'b0;
            ptr       <= '0;
            disparo_r <= '0;
        end else if (reiniciarJogo) begin
            cnt_tiro  <= '0;
            pendente  <= 1'b0;
            ptr       <= '0;
            disparo_r <= '0;
        end else if (estado == VITORIA) begin
            cnt_tiro  <= '0;
            pendente  <= 1'b0;
            disparo_r <= '0;
        end else begin
            disparo_r <= '0;
            if (ativo) begin
                if (pendente && achou) begin
                    disparo_r <= concessao;
                    ptr       <= escolhido;
                    pendente  <= 1'b0;
                end
                if (cnt_tiro == TIRO_FIM) begin
                    cnt_tiro <= '0;
                    pendente <= 1'b1;
                end else begin
                    cnt_tiro <= cnt_tiro + 1'b1;
                end
            end
        end
    end

endmodule
